// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg
//   Shared constants and helpers for the dsp_mac_pipe MAC slice:
//   opmode bit positions, the Z-mux select encoding and the width
//   helpers used to size the pre-adder and the product.
package dsp_mac_pkg;

  localparam int OPMODE_W      = 5;
  localparam int OP_USE_PREADD = 0;
  localparam int OP_PRE_SUB    = 1;
  localparam int OP_ZSEL_LO    = 2;
  localparam int OP_ZSEL_HI    = 3;
  localparam int OP_POST_SUB   = 4;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_P    = 2'd1,
    Z_C    = 2'd2,
    Z_RSVD = 2'd3
  } z_sel_e;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Product width: a times the (one-bit-grown) pre-adder result.
  function automatic int mult_w(input int a_w, input int b_w, input int d_w);
    return a_w + max_int(b_w, d_w) + 1;
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// dsp_mac_pipe_if
//   Sample/result bundle of the MAC slice.
//   master (sample source): drives in_valid, a, b, d, c, opmode, acc_clear;
//                           receives out_valid, m, p, overflow, ovf_sticky,
//                           pattern_det.
//   slave  (dsp_mac_pipe):  the mirror image.
interface dsp_mac_pipe_if #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int D_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48
);
  import dsp_mac_pkg::*;

  localparam int M_W = mult_w(A_W, B_W, D_W);

  logic                    in_valid;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic signed [D_W-1:0]   d;
  logic signed [C_W-1:0]   c;
  logic [OPMODE_W-1:0]     opmode;
  logic                    acc_clear;

  logic                    out_valid;
  logic signed [M_W-1:0]   m;
  logic signed [P_W-1:0]   p;
  logic                    overflow;
  logic                    ovf_sticky;
  logic                    pattern_det;

  modport master (
    output in_valid, a, b, d, c, opmode, acc_clear,
    input  out_valid, m, p, overflow, ovf_sticky, pattern_det
  );

  modport slave (
    input  in_valid, a, b, d, c, opmode, acc_clear,
    output out_valid, m, p, overflow, ovf_sticky, pattern_det
  );

endinterface

// File: rtl/dsp_sat_addsub.sv
// dsp_sat_addsub
//   Combinational signed add/subtract with overflow detect and optional clamp.
//   x, y : W-bit signed operands
//   sub  : 0 -> x + y, 1 -> x - y
//   sum  : W-bit result (clamped when SATURATE=1, wrapped otherwise)
//   ovf  : true result does not fit in W bits
module dsp_sat_addsub #(
  parameter int W        = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic                sub,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic [W:0] wide_s;

  // One guard bit: overflow is the guard bit disagreeing with the sign bit
  always_comb begin
    if (sub) begin
      wide_s = {x[W-1], x} - {y[W-1], y};
    end else begin
      wide_s = {x[W-1], x} + {y[W-1], y};
    end
    ovf = wide_s[W] ^ wide_s[W-1];
    if (SATURATE && ovf) begin
      // Guard bit carries the true sign of the result
      sum = wide_s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide_s[W-1:0];
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe
//   Three-stage signed MAC slice: S1 input registers, S2 pre-adder and
//   multiplier, S3 post-adder/accumulator with saturation and pattern detect.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ce    : global clock enable, low freezes every stage
//   bus   : sample inputs and registered results (dsp_mac_pipe_if.slave)
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int             A_W      = 18,
  parameter int             B_W      = 18,
  parameter int             D_W      = 18,
  parameter int             C_W      = 48,
  parameter int             P_W      = 48,
  parameter bit             SATURATE = 1'b1,
  parameter logic [P_W-1:0] PATTERN  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  dsp_mac_pipe_if.slave bus
);

  localparam int M_W   = mult_w(A_W, B_W, D_W);
  localparam int PRE_W = max_int(B_W, D_W) + 1;

  // S1 registers
  logic                  vld1_q, vld1_d;
  logic signed [A_W-1:0] a1_q, a1_d;
  logic signed [B_W-1:0] b1_q, b1_d;
  logic signed [D_W-1:0] d1_q, d1_d;
  logic signed [C_W-1:0] c1_q, c1_d;
  logic [OPMODE_W-1:0]   op1_q, op1_d;
  logic                  clr1_q, clr1_d;

  // S2 registers: product plus the sideband S3 still needs
  logic                  vld2_q, vld2_d;
  logic signed [M_W-1:0] prod2_q, prod2_d;
  logic signed [C_W-1:0] c2_q, c2_d;
  z_sel_e                zsel2_q, zsel2_d;
  logic                  post_sub2_q, post_sub2_d;
  logic                  clr2_q, clr2_d;

  // S3 registers: the visible results
  logic                  vld3_q, vld3_d;
  logic signed [M_W-1:0] m3_q, m3_d;
  logic signed [P_W-1:0] p3_q, p3_d;
  logic                  ovf3_q, ovf3_d;
  logic                  sticky3_q, sticky3_d;
  logic                  pat3_q, pat3_d;

  // Combinational datapath
  logic signed [PRE_W-1:0] pre_b_s, pre_d_s, mop_s;
  logic signed [M_W-1:0]   a_ext_s, mop_ext_s;
  logic signed [P_W-1:0]   z_s, m_ext_s, sum_s;
  logic                    ovf_s;

  // S1 next state: capture raw sample and controls
  always_comb begin
    vld1_d = bus.in_valid;
    a1_d   = bus.a;
    b1_d   = bus.b;
    d1_d   = bus.d;
    c1_d   = bus.c;
    op1_d  = bus.opmode;
    clr1_d = bus.acc_clear;
  end

  // S2 next state: pre-adder (one bit of growth, cannot overflow) and multiply
  always_comb begin
    pre_b_s = PRE_W'(b1_q);
    pre_d_s = PRE_W'(d1_q);
    if (op1_q[OP_USE_PREADD]) begin
      if (op1_q[OP_PRE_SUB]) begin
        mop_s = pre_d_s - pre_b_s;
      end else begin
        mop_s = pre_d_s + pre_b_s;
      end
    end else begin
      mop_s = pre_b_s;
    end
    // Both factors widened to M_W: the low M_W bits hold the exact product
    a_ext_s     = M_W'(a1_q);
    mop_ext_s   = M_W'(mop_s);
    prod2_d     = a_ext_s * mop_ext_s;
    vld2_d      = vld1_q;
    c2_d        = c1_q;
    zsel2_d     = z_sel_e'(op1_q[OP_ZSEL_HI:OP_ZSEL_LO]);
    post_sub2_d = op1_q[OP_POST_SUB];
    clr2_d      = clr1_q;
  end

  // S3 Z mux: acc_clear wins over z_sel; feedback uses the live p register
  always_comb begin
    m_ext_s = P_W'(prod2_q);
    if (clr2_q) begin
      z_s = {P_W{1'b0}};
    end else begin
      case (zsel2_q)
        Z_ZERO:  z_s = {P_W{1'b0}};
        Z_P:     z_s = p3_q;
        Z_C:     z_s = P_W'(c2_q);
        default: z_s = {P_W{1'b0}};
      endcase
    end
  end

  dsp_sat_addsub #(
    .W        (P_W),
    .SATURATE (SATURATE)
  ) u_post_add (
    .x   (z_s),
    .y   (m_ext_s),
    .sub (post_sub2_q),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // S3 next state: results load only for valid samples, bubbles hold them
  always_comb begin
    vld3_d = vld2_q;
    if (vld2_q) begin
      m3_d      = prod2_q;
      p3_d      = sum_s;
      ovf3_d    = ovf_s;
      sticky3_d = (clr2_q ? 1'b0 : sticky3_q) | ovf_s;
      pat3_d    = (sum_s == PATTERN);
    end else begin
      m3_d      = m3_q;
      p3_d      = p3_q;
      ovf3_d    = ovf3_q;
      sticky3_d = sticky3_q;
      pat3_d    = pat3_q;
    end
  end

  // Pipeline registers; ce low freezes every stage including valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q      <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      d1_q        <= '0;
      c1_q        <= '0;
      op1_q       <= '0;
      clr1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      prod2_q     <= '0;
      c2_q        <= '0;
      zsel2_q     <= Z_ZERO;
      post_sub2_q <= 1'b0;
      clr2_q      <= 1'b0;
      vld3_q      <= 1'b0;
      m3_q        <= '0;
      p3_q        <= '0;
      ovf3_q      <= 1'b0;
      sticky3_q   <= 1'b0;
      pat3_q      <= (PATTERN == {P_W{1'b0}});
    end else if (ce) begin
      vld1_q      <= vld1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      d1_q        <= d1_d;
      c1_q        <= c1_d;
      op1_q       <= op1_d;
      clr1_q      <= clr1_d;
      vld2_q      <= vld2_d;
      prod2_q     <= prod2_d;
      c2_q        <= c2_d;
      zsel2_q     <= zsel2_d;
      post_sub2_q <= post_sub2_d;
      clr2_q      <= clr2_d;
      vld3_q      <= vld3_d;
      m3_q        <= m3_d;
      p3_q        <= p3_d;
      ovf3_q      <= ovf3_d;
      sticky3_q   <= sticky3_d;
      pat3_q      <= pat3_d;
    end
  end

  assign bus.out_valid   = vld3_q;
  assign bus.m           = m3_q;
  assign bus.p           = p3_q;
  assign bus.overflow    = ovf3_q;
  assign bus.ovf_sticky  = sticky3_q;
  assign bus.pattern_det = pat3_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe
//   Directed bench for dsp_mac_pipe. Three slices share one stimulus:
//   bus0 (defaults, P_W=48), bus40s (P_W=40 saturating), bus40w (P_W=40 wrap).
module tb_dsp_mac_pipe;

  localparam longint PROD = 64'sd17179607041;   // 131071 * 131071
  localparam longint SMAX = 64'sd549755813887;  // 2^39 - 1

  logic                clk;
  logic                rst_n;
  logic                ce;
  logic                in_valid;
  logic signed [17:0]  a, b, d;
  logic signed [47:0]  c;
  logic [4:0]          opmode;
  logic                acc_clear;

  int n_checks = 0;
  int n_errors = 0;

  dsp_mac_pipe_if #(.C_W(48), .P_W(48)) bus0 ();
  dsp_mac_pipe_if #(.C_W(40), .P_W(40)) bus40s ();
  dsp_mac_pipe_if #(.C_W(40), .P_W(40)) bus40w ();

  assign bus0.in_valid    = in_valid;
  assign bus0.a           = a;
  assign bus0.b           = b;
  assign bus0.d           = d;
  assign bus0.c           = c;
  assign bus0.opmode      = opmode;
  assign bus0.acc_clear   = acc_clear;
  assign bus40s.in_valid  = in_valid;
  assign bus40s.a         = a;
  assign bus40s.b         = b;
  assign bus40s.d         = d;
  assign bus40s.c         = c[39:0];
  assign bus40s.opmode    = opmode;
  assign bus40s.acc_clear = acc_clear;
  assign bus40w.in_valid  = in_valid;
  assign bus40w.a         = a;
  assign bus40w.b         = b;
  assign bus40w.d         = d;
  assign bus40w.c         = c[39:0];
  assign bus40w.opmode    = opmode;
  assign bus40w.acc_clear = acc_clear;

  dsp_mac_pipe #(.C_W(48), .P_W(48), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus0)
  );
  dsp_mac_pipe #(.C_W(40), .P_W(40), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus40s)
  );
  dsp_mac_pipe #(.C_W(40), .P_W(40), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus40w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [17:0] ia,
                       input logic signed [17:0] ib, input logic signed [17:0] id,
                       input logic signed [47:0] ic, input logic [4:0] op,
                       input logic clr);
    in_valid  = v;
    a         = ia;
    b         = ib;
    d         = id;
    c         = ic;
    opmode    = op;
    acc_clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 18'sd0, 18'sd0, 18'sd0, 48'sd0, 5'b00000, 1'b0);
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated sample: out_valid must rise exactly on the third edge
  task automatic run_single(input string tag, input logic signed [17:0] ia,
                            input logic signed [17:0] ib, input logic signed [17:0] id,
                            input logic signed [47:0] ic, input logic [4:0] op,
                            input logic signed [63:0] exp_m,
                            input logic signed [63:0] exp_p);
    drive(1'b1, ia, ib, id, ic, op, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      step();
      if (e == 1) idle();
      check_eq({tag, "_vld"}, bus0.out_valid, (e == 3));
    end
    check_eq({tag, "_m"}, bus0.m, exp_m);
    check_eq({tag, "_p"}, bus0.p, exp_p);
    step();
    check_eq({tag, "_vld_drop"}, bus0.out_valid, 64'sd0);
  endtask

  logic        acc_v   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [47:0] acc_exp [5] = '{48'd6, 48'd12, 48'd12, 48'd18, 48'd24};

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    idle();
    #12;
    check_eq("rst_vld", bus0.out_valid, 64'sd0);
    check_eq("rst_m", bus0.m, 64'sd0);
    check_eq("rst_p", bus0.p, 64'sd0);
    check_eq("rst_ovf", bus0.overflow, 64'sd0);
    check_eq("rst_sticky", bus0.ovf_sticky, 64'sd0);
    check_eq("rst_pat", bus0.pattern_det, 64'sd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pre-adder: 1 * (10 + 0) + c(5)
    run_single("preadd", 18'sd1, 18'sd0, 18'sd10, 48'sd5, 5'b01001, 64'sd10, 64'sd15);
    // Signed: -3 * (5 - 7) = 6; 10 - 6 = 4
    run_single("signed", -18'sd3, 18'sd7, 18'sd5, 48'sd10, 5'b11011, 64'sd6, 64'sd4);

    // Accumulate 2*3 with acc_clear on first sample and one bubble
    for (int k = 0; k < 7; k++) begin
      if (k < 5) drive(acc_v[k], 18'sd2, 18'sd3, 18'sd0, 48'sd0, 5'b00100, (k == 0));
      else       idle();
      step();
      if (k >= 2) begin
        check_eq("acc_vld", bus0.out_valid, acc_v[k-2]);
        check_eq("acc_p", bus0.p, $signed({16'd0, acc_exp[k-2]}));
      end
    end

    // Pattern / stall: zero result then 4*5, with a 2-cycle ce stall between
    drive(1'b1, 18'sd7, 18'sd0, 18'sd0, 48'sd0, 5'b01001, 1'b0);
    step();
    drive(1'b1, 18'sd4, 18'sd5, 18'sd0, 48'sd0, 5'b00000, 1'b0);
    step();
    idle();
    step();
    check_eq("pat_vld", bus0.out_valid, 64'sd1);
    check_eq("pat_p", bus0.p, 64'sd0);
    check_eq("pat_det1", bus0.pattern_det, 64'sd1);
    ce = 1'b0;
    for (int s = 0; s < 2; s++) begin
      step();
      check_eq("stall_vld", bus0.out_valid, 64'sd1);
      check_eq("stall_p", bus0.p, 64'sd0);
      check_eq("stall_pat", bus0.pattern_det, 64'sd1);
    end
    ce = 1'b1;
    step();
    check_eq("stall_out_vld", bus0.out_valid, 64'sd1);
    check_eq("stall_out_m", bus0.m, 64'sd20);
    check_eq("stall_out_p", bus0.p, 64'sd20);
    check_eq("pat_det0", bus0.pattern_det, 64'sd0);
    step();
    check_eq("stall_vld_drop", bus0.out_valid, 64'sd0);

    // Saturation on P_W=40: samples 1 and 36 carry acc_clear
    for (int k = 0; k < 38; k++) begin
      drive(1'b1, 18'sd131071, 18'sd131071, 18'sd0, 48'sd0, 5'b00100,
            (k == 0) || (k == 35));
      step();
      if (k >= 2) begin
        if (k - 1 <= 32) check_eq("sat_exact", bus40s.p, PROD * (k - 1));
        if (k - 1 == 32) check_eq("sat_ovf32", bus40s.overflow, 64'sd0);
        if (k - 1 == 33) begin
          check_eq("sat_clamp", bus40s.p, SMAX);
          check_eq("sat_ovf", bus40s.overflow, 64'sd1);
          check_eq("sat_sticky", bus40s.ovf_sticky, 64'sd1);
          check_eq("wrap_p", bus40w.p, -64'sd532584595423);
          check_eq("wrap_ovf", bus40w.overflow, 64'sd1);
        end
        if (k - 1 == 35) begin
          check_eq("sat_hold", bus40s.p, SMAX);
          check_eq("sat_sticky_hold", bus40s.ovf_sticky, 64'sd1);
        end
        if (k - 1 == 36) begin
          check_eq("clr_p", bus40s.p, PROD);
          check_eq("clr_ovf", bus40s.overflow, 64'sd0);
          check_eq("clr_sticky", bus40s.ovf_sticky, 64'sd0);
        end
      end
    end
    step();

    // Mid-stream asynchronous reset with samples in flight
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", bus40s.out_valid, 64'sd0);
    check_eq("arst_p", bus40s.p, 64'sd0);
    check_eq("arst_m", bus40s.m, 64'sd0);
    check_eq("arst_pat", bus0.pattern_det, 64'sd1);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check_eq("flush_vld", bus0.out_valid, 64'sd0);
    end
    run_single("post_rst", 18'sd3, 18'sd4, 18'sd0, 48'sd0, 5'b00000, 64'sd12, 64'sd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised signed multiply-accumulate slice, the next generation of our DSP48A1-style slice. Datapath: pre-adder, multiplier, post-adder/accumulator, each with a pipeline stage. New relative to the fixed 18/48-bit slice:
- generic operand widths;
- a valid pipeline;
- saturating two's-complement arithmetic with sticky overflow;
- a per-sample accumulator clear;
- pattern detect.

It sits between sample sources (filters, correlators) and downstream result consumers.

## Interface
- A_W, 18, width of signed a
- B_W, 18, width of signed b
- D_W, 18, width of signed d
- C_W, 48, width of signed c; must satisfy C_W <= P_W
- P_W, 48, accumulator/result width; must satisfy P_W >= M_W+1
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap
- PATTERN, 0, P_W-bit value compared for pattern_det
- Derived: M_W = A_W + max(B_W,D_W) + 1 (localparam)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ce  in  1  global clock enable; low freezes every stage
- in_valid  in  1  sample qualifier
- a  in  A_W  signed multiplicand
- b  in  B_W  signed pre-adder operand
- d  in  D_W  signed pre-adder operand
- c  in  C_W  signed post-adder operand
- opmode  in  5  bit 0 use_preadd, bit 1 pre_sub, bits 3:2 z_sel, bit 4 post_sub
- acc_clear  in  1  per-sample: force Z=0 and clear ovf_sticky
- out_valid  out  1  p/m/flags qualify a new result
- m  out  M_W  registered product
- p  out  P_W  registered result
- overflow  out  1  this result overflowed
- ovf_sticky  out  1  overflow seen since last acc_clear
- pattern_det  out  1  p == PATTERN

## Operation
Stages, each advancing only when ce=1:
- **S1:** register a, b, d, c, opmode, acc_clear and in_valid.
- **S2, pre-adder:** the multiplier operand is `d±b` if use_preadd=1 (+ if pre_sub=0, − if pre_sub=1), otherwise b sign-extended.
  - Pre-adder width is max(B_W,D_W)+1, so it never overflows.
  - The full M_W-bit product is registered into m along with the sideband.
- **S3, post-adder:** `P_next = Z + m` if post_sub=0, or `Z − m` if post_sub=1. m is sign-extended to P_W; the sum is computed at P_W+1 bits.
- **Z selection:**
  - z_sel=0: zero
  - z_sel=1: current p register (accumulate)
  - z_sel=2: c, sign-extended
  - z_sel=3: reserved, treated as zero
  - acc_clear overrides z_sel and forces Z=0.
- **Overflow:** raised when the top two bits of the P_W+1-bit sum differ.
  - SATURATE=1: p is clamped to +2^(P_W−1)−1 or −2^(P_W−1).
  - SATURATE=0: p takes the low P_W bits.
- **S3 register update:** p, overflow and pattern_det load only when S2 valid=1 and ce=1. Otherwise p holds (bubbles do not disturb the accumulator) and overflow/pattern_det hold.
- **ovf_sticky:** on a valid S3 update, `ovf_sticky <= (acc_clear ? 0 : ovf_sticky) | overflow_new`.
- **pattern_det:** compares the final (post-saturation) p value.

## Timing
- Latency: a sample presented with in_valid=1 at edge N (ce=1 throughout) produces out_valid=1 with its results after edge N+3.
- Throughput: one sample per cycle; no backpressure.
- ce=0: every register, including the valid pipeline, holds. out_valid stays at its last value; latency extends by the number of stalled cycles.
- Back-to-back z_sel=1 samples accumulate correctly, since p feedback is the previous cycle's S3 result.
- Reset: every register clears immediately (asynchronous) — m=0, p=0, out_valid=0, overflow=0, ovf_sticky=0, pattern_det=(PATTERN==0).
- Reset release mid-stream flushes all in-flight samples; first out_valid comes 3 cycles after the first post-reset in_valid.
- acc_clear together with z_sel=1 acts as "start new accumulation with this product".

## Structure
- Package `dsp_mac_pkg`:
  - opmode bit-position constants;
  - z_sel enum (Z_ZERO, Z_P, Z_C, Z_RSVD);
  - max/width helper function for M_W.
- Sub-module `dsp_sat_addsub` (parameter W, SATURATE): combinational signed add/sub, producing result and overflow. It is instantiated once in S3.

## Test plan
- **Reset:** assert rst_n=0 mid-stream → all outputs 0 immediately; out_valid=0 until 3 cycles after next in_valid.
- **Pre-adder path:** a=1, d=10, b=0, c=5, opmode use_preadd=1, z_sel=C → p=15, m=10, out_valid exactly 3 edges after input.
- **Signed arithmetic:** a=−3, d=5, b=7, pre_sub=1, post_sub=1, c=10, z_sel=C → m=6, p=4.
- **Accumulate:** a=2, b=3, no preadd, z_sel=P, four consecutive samples, first with acc_clear → p=6, 12, 18, 24 on consecutive cycles. A bubble inserted between samples leaves p unchanged.
- **Saturation (P_W=40):** a=b=131071, z_sel=P → first 32 samples exact (32nd p=549747425312); 33rd gives p=2^39−1, overflow=1, ovf_sticky=1; further samples stay clamped. The next acc_clear sample clears sticky. With SATURATE=0 the 33rd result wraps negative.
- **Stall/pattern:** ce=0 for 2 cycles mid-stream → all outputs frozen, latency +2. d=b=0 path with c=0, PATTERN=0 → pattern_det=1; nonzero result → pattern_det=0.
